// File: rtl/day_count_ctrl.sv
// -----------------------------------------------------------------------------
// day_count_ctrl
//   Day-index counter for a "days elapsed" demo. Four raw push buttons are
//   synchronised and edge-detected. Their presses drive a three-state run
//   controller (IDLE / RUN / PAUSE). In RUN, a programmable prescaler advances
//   the count every BASE_DIV >> speed clock cycles. The count is also kept as
//   two BCD digits, registered together with the binary value.
//
// Parameters
//   BASE_DIV   : prescaler period at speed 0, in clock cycles (8 .. 2^23-1)
//   MAX_COUNT  : highest count value before wrapping to 1 (2 .. 99)
//
// Ports
//   ADC_CLK_10  in   1  clock; all state changes on its rising edge
//   reset       in   1  asynchronous, active-high reset
//   key_run_n   in   1  raw active-low run/pause button
//   key_step_n  in   1  raw active-low single-step button
//   key_speed_n in   1  raw active-low speed-cycle button
//   key_clear_n in   1  raw active-low clear button
//   count       out  7  current day index, 1 .. MAX_COUNT
//   ones        out  4  BCD ones digit of count
//   tens        out  4  BCD tens digit of count
//   tick        out  1  one-cycle pulse in the cycle count changes
//   wrap        out  1  one-cycle pulse with tick when count goes MAX_COUNT -> 1
//   running     out  1  high only while in RUN
//   speed       out  2  current speed selection, 0 .. 3
// -----------------------------------------------------------------------------
module day_count_ctrl #(
    parameter int BASE_DIV  = 5000000,
    parameter int MAX_COUNT = 99
) (
    input  logic       ADC_CLK_10,
    input  logic       reset,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       key_speed_n,
    input  logic       key_clear_n,
    output logic [6:0] count,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tick,
    output logic       wrap,
    output logic       running,
    output logic [1:0] speed
);

    localparam logic [6:0]  MAX_CNT = 7'(MAX_COUNT);
    localparam logic [22:0] BASE_P  = 23'(BASE_DIV);

    // Key vector bit positions.
    localparam int K_RUN   = 0;
    localparam int K_STEP  = 1;
    localparam int K_SPEED = 2;
    localparam int K_CLEAR = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Key synchronisers and falling-edge detectors
    // -------------------------------------------------------------------------
    logic [3:0] w_keys_n;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] r_armed;
    logic [1:0] r_fill;
    logic [3:0] w_press;

    assign w_keys_n = {key_clear_n, key_speed_n, key_step_n, key_run_n};

    // r_fill counts the two cycles the synchroniser needs after reset before
    // r_sync2 holds a real sample. A key only becomes armed once it has been
    // seen released, so a button held through reset release never reports a
    // press when the pipeline fills with its low level.
    // NOTE: clocked state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
            r_armed <= '0;
            r_fill  <= '0;
        end else begin
            r_sync1 <= w_keys_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end else begin
                r_armed <= r_armed | r_sync2;
            end
        end
    end

    assign w_press = r_armed & r_prev & ~r_sync2;

    logic w_press_run;
    logic w_press_step;
    logic w_press_speed;
    logic w_press_clear;

    assign w_press_run   = w_press[K_RUN];
    assign w_press_step  = w_press[K_STEP];
    assign w_press_speed = w_press[K_SPEED];
    assign w_press_clear = w_press[K_CLEAR];

    // -------------------------------------------------------------------------
    // Run controller
    // -------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [22:0] r_presc;
    logic [1:0]  r_speed;
    logic [22:0] w_period;
    logic [22:0] w_period_m1;
    logic        w_advance;
    logic        w_presc_clr;
    logic        w_presc_inc;

    assign w_period    = BASE_P >> r_speed;
    assign w_period_m1 = w_period - 23'd1;

    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority: clear over run over step. A speed press is independent, but it
    // restarts the prescaler, so it also cancels a RUN advance in that cycle.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_presc_clr  = 1'b0;
        w_presc_inc  = 1'b0;

        if (w_press_clear) begin
            w_state_next = S_IDLE;
            w_presc_clr  = 1'b1;
        end else if (w_press_run) begin
            w_presc_clr = 1'b1;
            case (r_state)
                S_IDLE:  w_state_next = S_RUN;
                S_RUN:   w_state_next = S_PAUSE;
                S_PAUSE: w_state_next = S_RUN;
                default: w_state_next = S_IDLE;
            endcase
        end else if (w_press_step && (r_state != S_RUN)) begin
            w_advance = 1'b1;
            if (r_state == S_IDLE) begin
                w_state_next = S_PAUSE;
            end
        end else if ((r_state == S_RUN) && !w_press_speed) begin
            if (r_presc == w_period_m1) begin
                w_advance   = 1'b1;
                w_presc_clr = 1'b1;
            end else begin
                w_presc_inc = 1'b1;
            end
        end

        if (w_press_speed) begin
            w_presc_clr = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Count, BCD digits, pulses, prescaler and speed
    // -------------------------------------------------------------------------
    logic [6:0] r_count;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_tick;
    logic       r_wrap;

    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            r_count <= 7'd1;
            r_ones  <= 4'd1;
            r_tens  <= 4'd0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_presc <= '0;
            r_speed <= 2'd0;
        end else begin
            r_tick <= w_advance;
            r_wrap <= w_advance && (r_count == MAX_CNT);

            if (w_press_clear) begin
                r_count <= 7'd1;
                r_ones  <= 4'd1;
                r_tens  <= 4'd0;
            end else if (w_advance) begin
                if (r_count == MAX_CNT) begin
                    r_count <= 7'd1;
                    r_ones  <= 4'd1;
                    r_tens  <= 4'd0;
                end else begin
                    r_count <= r_count + 7'd1;
                    // The digits step with the binary value so they never lag it.
                    if (r_ones == 4'd9) begin
                        r_ones <= 4'd0;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_ones <= r_ones + 4'd1;
                    end
                end
            end

            if (w_presc_clr) begin
                r_presc <= '0;
            end else if (w_presc_inc) begin
                r_presc <= r_presc + 23'd1;
            end

            // Two-bit counter wraps 3 -> 0 on its own.
            if (w_press_speed) begin
                r_speed <= r_speed + 2'd1;
            end
        end
    end

    assign count   = r_count;
    assign ones    = r_ones;
    assign tens    = r_tens;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign running = (r_state == S_RUN);
    assign speed   = r_speed;

endmodule

// File: tb/tb_day_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_day_count_ctrl
//   Self-checking bench for day_count_ctrl with BASE_DIV=8, MAX_COUNT=99.
//   A behavioural model follows the documented rules: a press is a high-to-low
//   key transition seen two samples late, and the run state, period and
//   advance/wrap behaviour are computed with plain integers. Outputs are
//   compared on every falling clock edge, then directed scenarios and a
//   random phase drive the buttons.
// -----------------------------------------------------------------------------
module tb_day_count_ctrl;

    localparam int BASE_DIV  = 8;
    localparam int MAX_COUNT = 99;

    localparam int K_RUN   = 0;
    localparam int K_STEP  = 1;
    localparam int K_SPEED = 2;
    localparam int K_CLEAR = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_run_n;
    logic       key_step_n;
    logic       key_speed_n;
    logic       key_clear_n;
    logic [6:0] count;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tick;
    logic       wrap;
    logic       running;
    logic [1:0] speed;

    always #5 clk = ~clk;

    day_count_ctrl #(
        .BASE_DIV (BASE_DIV),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .ADC_CLK_10 (clk),
        .reset      (reset),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .key_speed_n(key_speed_n),
        .key_clear_n(key_clear_n),
        .count      (count),
        .ones       (ones),
        .tens       (tens),
        .tick       (tick),
        .wrap       (wrap),
        .running    (running),
        .speed      (speed)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------------------------------------------------------- model
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;

    mstate_t m_state;
    int      m_count;
    int      m_speed;
    int      m_elapsed;   // RUN cycles since the period last restarted
    int      m_tick;
    int      m_wrap;
    bit      hist[4][3];  // key level seen 1, 2, 3 edges ago (0 while in reset)

    task automatic model_reset();
        m_state   = M_IDLE;
        m_count   = 1;
        m_speed   = 0;
        m_elapsed = 0;
        m_tick    = 0;
        m_wrap    = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) hist[k][j] = 1'b0;
    endtask

    task automatic model_advance();
        if (m_count == MAX_COUNT) begin
            m_count = 1;
            m_wrap  = 1;
        end else begin
            m_count = m_count + 1;
        end
        m_tick = 1;
    endtask

    // Called once per rising edge with the inputs that edge samples.
    task automatic model_edge();
        bit cur[4];
        bit p[4];
        if (reset) begin
            model_reset();
            return;
        end
        cur[K_RUN]   = key_run_n;
        cur[K_STEP]  = key_step_n;
        cur[K_SPEED] = key_speed_n;
        cur[K_CLEAR] = key_clear_n;
        for (int k = 0; k < 4; k++) begin
            p[k]       = hist[k][2] && !hist[k][1];
            hist[k][2] = hist[k][1];
            hist[k][1] = hist[k][0];
            hist[k][0] = cur[k];
        end
        m_tick = 0;
        m_wrap = 0;
        if (p[K_CLEAR]) begin
            m_state   = M_IDLE;
            m_count   = 1;
            m_elapsed = 0;
        end else if (p[K_RUN]) begin
            m_state   = (m_state == M_RUN) ? M_PAUSE : M_RUN;
            m_elapsed = 0;
        end else if (p[K_STEP] && m_state != M_RUN) begin
            model_advance();
            if (m_state == M_IDLE) m_state = M_PAUSE;
        end else if (m_state == M_RUN && !p[K_SPEED]) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == (BASE_DIV >> m_speed)) begin
                model_advance();
                m_elapsed = 0;
            end
        end
        if (p[K_SPEED]) begin
            m_speed   = (m_speed + 1) % 4;
            m_elapsed = 0;
        end
    endtask

    task automatic compare_all();
        check("count",   count,   m_count);
        check("ones",    ones,    m_count % 10);
        check("tens",    tens,    m_count / 10);
        check("tick",    tick,    m_tick);
        check("wrap",    wrap,    m_wrap);
        check("running", running, (m_state == M_RUN) ? 1 : 0);
        check("speed",   speed,   m_speed);
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_RUN:   key_run_n   = v;
            K_STEP:  key_step_n  = v;
            K_SPEED: key_speed_n = v;
            default: key_clear_n = v;
        endcase
    endtask

    task automatic press(input int k, input int hold);
        set_key(k, 1'b0);
        repeat (hold) cycle();
        set_key(k, 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        #1;
        check({tag, "_count"},   count,   1);
        check({tag, "_ones"},    ones,    1);
        check({tag, "_tens"},    tens,    0);
        check({tag, "_tick"},    tick,    0);
        check({tag, "_wrap"},    wrap,    0);
        check({tag, "_running"}, running, 0);
        check({tag, "_speed"},   speed,   0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        reset_checks("rst_now");
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic wait_running();
        int n = 0;
        while (running !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
    endtask

    task automatic measure_period(output int gap);
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick !== 1'b1 && n < 20);
        gap = (tick === 1'b1) ? n : 0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        int gap;
        bit kv[4];

        reset       = 1'b1;
        key_run_n   = 1'b1;
        key_step_n  = 1'b1;
        key_speed_n = 1'b1;
        key_clear_n = 1'b1;
        model_reset();
        @(negedge clk);
        reset_checks("rst_init");
        repeat (3) cycle();
        reset = 1'b0;
        repeat (4) cycle();

        // Run: one tick every 8 cycles, count 4 after three ticks.
        press(K_RUN, 2);
        wait_running();
        check("run_running", running, 1);
        repeat (24) cycle();
        check("run3_count", count, 4);
        check("run3_ones",  ones,  4);
        check("run3_tens",  tens,  0);
        check("run3_tick",  tick,  1);

        // Wrap from MAX_COUNT back to 1.
        n = 0;
        while (count != 7'd99 && n < 1000) begin
            cycle();
            n++;
        end
        check("reach99_count", count, 99);
        check("reach99_tens",  tens,  9);
        check("reach99_ones",  ones,  9);
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick !== 1'b1 && n < 20);
        check("wrap_count", count, 1);
        check("wrap_pulse", wrap,  1);
        cycle();
        check("wrap_single", wrap, 0);

        // Speed cycling in RUN.
        repeat (3) begin
            press(K_SPEED, 1);
            repeat (3) cycle();
        end
        check("speed3", speed, 3);
        measure_period(gap);
        check("period_speed3", gap, 1);
        press(K_SPEED, 1);
        repeat (3) cycle();
        check("speed0", speed, 0);
        measure_period(gap);
        check("period_speed0", gap, 8);

        // Steps from IDLE, then a step ignored in RUN.
        do_reset(2);
        repeat (3) cycle();
        press(K_STEP, 2);
        repeat (3) cycle();
        press(K_STEP, 1);
        repeat (3) cycle();
        check("step2_count",   count,   3);
        check("step2_running", running, 0);
        press(K_RUN, 1);
        wait_running();
        press(K_STEP, 1);
        repeat (3) cycle();
        check("step_in_run_count", count, 3);

        // Clear and run together in RUN at count 42.
        do_reset(2);
        repeat (3) cycle();
        press(K_RUN, 1);
        n = 0;
        while (count != 7'd42 && n < 500) begin
            cycle();
            n++;
        end
        check("reach42", count, 42);
        key_clear_n = 1'b0;
        key_run_n   = 1'b0;
        repeat (2) cycle();
        key_clear_n = 1'b1;
        key_run_n   = 1'b1;
        repeat (4) cycle();
        check("clr_run_count",   count,   1);
        check("clr_run_running", running, 0);

        // Reset mid-prescale with run held low through release.
        press(K_RUN, 1);
        repeat (13) cycle();
        key_run_n = 1'b0;
        cycle();
        do_reset(3);
        repeat (5) cycle();
        key_run_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("post_rst_no_tick", tick, 0);
        end
        check("post_rst_running", running, 0);
        check("post_rst_count",   count,   1);

        // Random button activity, with occasional resets.
        for (int k = 0; k < 4; k++) kv[k] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    kv[k] = 1'b1;
                    set_key(k, 1'b1);
                end
                do_reset($urandom_range(3, 1));
            end
            for (int k = 0; k < 4; k++) begin
                if (kv[k]) begin
                    if ($urandom_range((k == K_CLEAR) ? 199 : 39) == 0) kv[k] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    kv[k] = 1'b1;
                end
                set_key(k, kv[k]);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
